// File: rtl/fpu_hazard_if.sv
// Decode-to-hazard-controller bundle: issue request, completion pulses,
// and the stall / scoreboard / writeback responses.
interface fpu_hazard_if;
    logic        issue_valid;
    logic [1:0]  issue_class;
    logic        issue_fwren;
    logic [4:0]  issue_waddr;
    logic        issue_rden1;
    logic        issue_rden2;
    logic        issue_rden3;
    logic [4:0]  issue_raddr1;
    logic [4:0]  issue_raddr2;
    logic [4:0]  issue_raddr3;
    logic        flush;
    logic        iter_ready;
    logic        load_done;

    logic        stall;
    logic        issue_accept;
    logic [31:0] pending;
    logic        iter_busy;
    logic        load_busy;
    logic        wb_valid;
    logic [4:0]  wb_waddr;

    // Handshake: an instruction is taken only in a cycle where issue_valid=1
    // and issue_accept=1; stall asks decode to hold the same instruction.
    modport master (
        output issue_valid, issue_class, issue_fwren, issue_waddr,
        output issue_rden1, issue_rden2, issue_rden3,
        output issue_raddr1, issue_raddr2, issue_raddr3,
        output flush, iter_ready, load_done,
        input  stall, issue_accept, pending, iter_busy, load_busy,
        input  wb_valid, wb_waddr
    );

    modport slave (
        input  issue_valid, issue_class, issue_fwren, issue_waddr,
        input  issue_rden1, issue_rden2, issue_rden3,
        input  issue_raddr1, issue_raddr2, issue_raddr3,
        input  flush, iter_ready, load_done,
        output stall, issue_accept, pending, iter_busy, load_busy,
        output wb_valid, wb_waddr
    );
endinterface

// File: rtl/fpu_hazard_ctrl.sv
// FP issue hazard controller: 32-entry pending scoreboard, FMA pipe tracker,
// iterative-unit and load tracking, and the registered multi-cycle writeback.
module fpu_hazard_ctrl #(
    parameter int unsigned FMA_LAT = 3
) (
    input  logic          clock,
    input  logic          reset,
    fpu_hazard_if.slave   hz
);

    // The accepting op itself is sr[FMA_LAT-1]; only the lower stages are flops,
    // so the registered sr[0] lands on wb exactly FMA_LAT cycles after accept.
    localparam int unsigned STAGES = FMA_LAT - 1;

    localparam logic [1:0] CLS_SINGLE = 2'd0;
    localparam logic [1:0] CLS_PIPE   = 2'd1;
    localparam logic [1:0] CLS_ITER   = 2'd2;
    localparam logic [1:0] CLS_LOAD   = 2'd3;

    logic [STAGES-1:0] pipe_vld_q, pipe_vld_d;
    logic [4:0]        pipe_addr_q [STAGES];
    logic [4:0]        pipe_addr_d [STAGES];

    logic [31:0] pend_q, pend_d;
    logic        iter_busy_q, iter_busy_d;
    logic        iter_fwren_q, iter_fwren_d;
    logic [4:0]  iter_waddr_q, iter_waddr_d;
    logic        load_busy_q, load_busy_d;
    logic [4:0]  load_waddr_q, load_waddr_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;

    logic raw, waw, struct_hz, port_hz;
    logic stall_c, accept_c;
    logic stage1_vld;

    generate
        if (STAGES >= 2) begin : g_stage1
            assign stage1_vld = pipe_vld_q[1];
        end else begin : g_no_stage1
            assign stage1_vld = 1'b0;
        end
    endgenerate

    // A source matching the result being written this cycle is forwarded by execute.
    always_comb begin
        raw = 1'b0;
        if (hz.issue_rden1 && pend_q[hz.issue_raddr1] &&
            !(wb_valid_q && hz.issue_raddr1 == wb_waddr_q))
            raw = 1'b1;
        if (hz.issue_rden2 && pend_q[hz.issue_raddr2] &&
            !(wb_valid_q && hz.issue_raddr2 == wb_waddr_q))
            raw = 1'b1;
        if (hz.issue_rden3 && pend_q[hz.issue_raddr3] &&
            !(wb_valid_q && hz.issue_raddr3 == wb_waddr_q))
            raw = 1'b1;
    end

    always_comb begin
        waw       = hz.issue_fwren && pend_q[hz.issue_waddr];
        struct_hz = iter_busy_q ||
                    (hz.issue_class == CLS_ITER && (|pipe_vld_q)) ||
                    (hz.issue_class == CLS_LOAD && load_busy_q);
        port_hz   = hz.issue_class == CLS_SINGLE && hz.issue_fwren && stage1_vld;
        stall_c   = hz.issue_valid && !hz.flush && (raw || waw || struct_hz || port_hz);
        accept_c  = hz.issue_valid && !stall_c && !hz.flush;
    end

    always_comb begin
        for (int i = 0; i < int'(STAGES) - 1; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i+1];
            pipe_addr_d[i] = pipe_addr_q[i+1];
        end
        pipe_vld_d[STAGES-1]  = accept_c && hz.issue_class == CLS_PIPE && hz.issue_fwren;
        pipe_addr_d[STAGES-1] = hz.issue_waddr;
    end

    always_comb begin
        iter_busy_d  = iter_busy_q;
        iter_fwren_d = iter_fwren_q;
        iter_waddr_d = iter_waddr_q;
        if (accept_c && hz.issue_class == CLS_ITER) begin
            iter_busy_d  = 1'b1;
            iter_fwren_d = hz.issue_fwren;
            iter_waddr_d = hz.issue_waddr;
        end else if (iter_busy_q && hz.iter_ready) begin
            iter_busy_d = 1'b0;
        end
    end

    always_comb begin
        load_busy_d  = load_busy_q;
        load_waddr_d = load_waddr_q;
        if (accept_c && hz.issue_class == CLS_LOAD) begin
            load_busy_d  = 1'b1;
            load_waddr_d = hz.issue_waddr;
        end else if (load_busy_q && hz.load_done) begin
            load_busy_d = 1'b0;
        end
    end

    // Pipe and iterative results never meet here: class 2 waits for an empty pipe
    // and nothing issues while the iterative unit is busy.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_waddr_d = 5'd0;
        if (pipe_vld_q[0]) begin
            wb_valid_d = 1'b1;
            wb_waddr_d = pipe_addr_q[0];
        end else if (iter_busy_q && hz.iter_ready && iter_fwren_q) begin
            wb_valid_d = 1'b1;
            wb_waddr_d = iter_waddr_q;
        end
    end

    // Set is applied last so it wins over a same-edge clear.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid_q)
            pend_d[wb_waddr_q] = 1'b0;
        if (load_busy_q && hz.load_done)
            pend_d[load_waddr_q] = 1'b0;
        if (accept_c && hz.issue_fwren && hz.issue_class != CLS_SINGLE)
            pend_d[hz.issue_waddr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_vld_q   <= '0;
            for (int i = 0; i < int'(STAGES); i++)
                pipe_addr_q[i] <= 5'd0;
            pend_q       <= '0;
            iter_busy_q  <= 1'b0;
            iter_fwren_q <= 1'b0;
            iter_waddr_q <= 5'd0;
            load_busy_q  <= 1'b0;
            load_waddr_q <= 5'd0;
            wb_valid_q   <= 1'b0;
            wb_waddr_q   <= 5'd0;
        end else begin
            pipe_vld_q   <= pipe_vld_d;
            for (int i = 0; i < int'(STAGES); i++)
                pipe_addr_q[i] <= pipe_addr_d[i];
            pend_q       <= pend_d;
            iter_busy_q  <= iter_busy_d;
            iter_fwren_q <= iter_fwren_d;
            iter_waddr_q <= iter_waddr_d;
            load_busy_q  <= load_busy_d;
            load_waddr_q <= load_waddr_d;
            wb_valid_q   <= wb_valid_d;
            wb_waddr_q   <= wb_waddr_d;
        end
    end

    assign hz.stall        = stall_c;
    assign hz.issue_accept = accept_c;
    assign hz.pending      = pend_q;
    assign hz.iter_busy    = iter_busy_q;
    assign hz.load_busy    = load_busy_q;
    assign hz.wb_valid     = wb_valid_q;
    assign hz.wb_waddr     = wb_waddr_q;

endmodule

// File: tb/tb_fpu_hazard_ctrl.sv
// Bench for fpu_hazard_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a time-stamped event model.
module tb_fpu_hazard_ctrl;
    localparam int L = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fpu_hazard_if hz();

    fpu_hazard_ctrl #(.FMA_LAT(L)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Results are tracked as (writeback cycle, register) events rather than stages.
    typedef struct {
        int         cyc;
        logic [4:0] addr;
    } wb_ev_t;

    wb_ev_t     pipe_q[$];
    wb_ev_t     iter_q[$];
    bit         m_pend [32];
    bit         m_ibusy, m_ifw, m_lbusy;
    logic [4:0] m_iaddr, m_laddr;

    function automatic bit src_hz(input logic en, input logic [4:0] a,
                                  input bit wbv, input logic [4:0] wba);
        return en && m_pend[a] && !(wbv && a == wba);
    endfunction

    always @(negedge clock) begin : compare
        bit         wbv, pipe_any, sr1, raw, waw, strct, port, e_stall, e_acc;
        logic [4:0] wba;
        logic [31:0] pend_vec;
        wbv = 0; wba = 0; pipe_any = 0; sr1 = 0;
        foreach (pipe_q[k]) begin
            if (pipe_q[k].cyc == cyc) begin wbv = 1; wba = pipe_q[k].addr; end
            if (pipe_q[k].cyc > cyc) pipe_any = 1;
            if (pipe_q[k].cyc == cyc + 2) sr1 = 1;
        end
        foreach (iter_q[k])
            if (iter_q[k].cyc == cyc) begin wbv = 1; wba = iter_q[k].addr; end

        raw = src_hz(hz.issue_rden1, hz.issue_raddr1, wbv, wba) ||
              src_hz(hz.issue_rden2, hz.issue_raddr2, wbv, wba) ||
              src_hz(hz.issue_rden3, hz.issue_raddr3, wbv, wba);
        waw   = hz.issue_fwren && m_pend[hz.issue_waddr];
        strct = m_ibusy || (hz.issue_class == 2 && pipe_any) || (hz.issue_class == 3 && m_lbusy);
        port  = hz.issue_class == 0 && hz.issue_fwren && sr1;
        e_stall = hz.issue_valid && !hz.flush && (raw || waw || strct || port);
        e_acc   = hz.issue_valid && !e_stall && !hz.flush;
        for (int k = 0; k < 32; k++) pend_vec[k] = m_pend[k];

        if (armed) begin
            chk("stall", hz.stall, e_stall);
            chk("issue_accept", hz.issue_accept, e_acc);
            chk("pending", hz.pending, pend_vec);
            chk("iter_busy", hz.iter_busy, m_ibusy);
            chk("load_busy", hz.load_busy, m_lbusy);
            chk("wb_valid", hz.wb_valid, wbv);
            if (wbv) chk("wb_waddr", hz.wb_waddr, wba);
        end

        if (reset) begin
            pipe_q.delete();
            iter_q.delete();
            foreach (m_pend[k]) m_pend[k] = 0;
            m_ibusy = 0; m_ifw = 0; m_lbusy = 0; m_iaddr = 0; m_laddr = 0;
            armed = 1'b1;
        end else begin
            if (wbv) m_pend[wba] = 0;
            if (m_lbusy && hz.load_done) begin
                m_pend[m_laddr] = 0;
                m_lbusy = 0;
            end
            if (m_ibusy && hz.iter_ready) begin
                m_ibusy = 0;
                if (m_ifw) iter_q.push_back('{cyc + 1, m_iaddr});
            end
            if (e_acc) begin
                case (hz.issue_class)
                    2'd1: if (hz.issue_fwren) pipe_q.push_back('{cyc + L, hz.issue_waddr});
                    2'd2: begin m_ibusy = 1; m_ifw = hz.issue_fwren; m_iaddr = hz.issue_waddr; end
                    2'd3: begin m_lbusy = 1; m_laddr = hz.issue_waddr; end
                    default: ;
                endcase
                if (hz.issue_fwren && hz.issue_class != 0) m_pend[hz.issue_waddr] = 1;
            end
            while (pipe_q.size() > 0 && pipe_q[0].cyc <= cyc) void'(pipe_q.pop_front());
            while (iter_q.size() > 0 && iter_q[0].cyc <= cyc) void'(iter_q.pop_front());
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic idle();
        hz.issue_valid  = 0; hz.issue_class = 0; hz.issue_fwren = 0; hz.issue_waddr = 0;
        hz.issue_rden1  = 0; hz.issue_rden2 = 0; hz.issue_rden3 = 0;
        hz.issue_raddr1 = 0; hz.issue_raddr2 = 0; hz.issue_raddr3 = 0;
        hz.flush = 0; hz.iter_ready = 0; hz.load_done = 0;
    endtask

    task automatic issue(input logic [1:0] c, input logic fw, input logic [4:0] wa,
                         input logic en1, input logic [4:0] a1);
        idle();
        hz.issue_valid = 1; hz.issue_class = c; hz.issue_fwren = fw; hz.issue_waddr = wa;
        hz.issue_rden1 = en1; hz.issue_raddr1 = a1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        at_neg();
        chk("reset_pending", hz.pending, 32'h0);
        chk("reset_wb_valid", hz.wb_valid, 0);
        chk("reset_wb_waddr", hz.wb_waddr, 0);
        chk("reset_iter_busy", hz.iter_busy, 0);
        chk("reset_load_busy", hz.load_busy, 0);
        tick();

        // fmul f3 then a dependent fadd: two stall cycles, accept on bypass
        issue(1, 1, 3, 0, 0);
        at_neg(); chk("fmul_accept", hz.issue_accept, 1); tick();
        issue(1, 1, 4, 1, 3);
        at_neg(); chk("raw_stall_1", hz.stall, 1); chk("pend3_set", hz.pending[3], 1); tick();
        at_neg(); chk("raw_stall_2", hz.stall, 1); tick();
        at_neg();
        chk("bypass_wb_valid", hz.wb_valid, 1);
        chk("bypass_wb_waddr", hz.wb_waddr, 3);
        chk("bypass_accept", hz.issue_accept, 1);
        tick(); idle();
        at_neg(); chk("pend3_clear", hz.pending[3], 0);
        repeat (6) tick();

        // fdiv f5 blocks everything until iter_ready
        issue(2, 1, 5, 0, 0);
        at_neg(); chk("fdiv_accept", hz.issue_accept, 1); tick();
        issue(0, 1, 9, 0, 0);
        at_neg(); chk("iter_busy_set", hz.iter_busy, 1); chk("iter_stall_1", hz.stall, 1); tick();
        at_neg(); chk("iter_stall_2", hz.stall, 1); tick();
        hz.iter_ready = 1;
        at_neg(); chk("iter_stall_ready", hz.stall, 1); tick();
        hz.iter_ready = 0;
        at_neg();
        chk("iter_wb_valid", hz.wb_valid, 1);
        chk("iter_wb_waddr", hz.wb_waddr, 5);
        chk("iter_busy_clear", hz.iter_busy, 0);
        chk("iter_after_accept", hz.issue_accept, 1);
        tick(); idle(); repeat (6) tick();

        // writeback port conflict: class 0 behind a fresh fmul
        issue(1, 1, 1, 0, 0);
        at_neg(); chk("port_fmul_accept", hz.issue_accept, 1); tick();
        issue(0, 1, 2, 0, 0);
        at_neg(); chk("port_stall", hz.stall, 1); tick();
        at_neg(); chk("port_accept", hz.issue_accept, 1); tick();
        idle(); repeat (6) tick();

        // one outstanding load
        issue(3, 1, 7, 0, 0);
        at_neg(); chk("load1_accept", hz.issue_accept, 1); tick();
        issue(3, 1, 8, 0, 0);
        at_neg(); chk("load_stall_1", hz.stall, 1); chk("load_busy_set", hz.load_busy, 1); tick();
        at_neg(); chk("load_stall_2", hz.stall, 1); tick();
        hz.load_done = 1;
        at_neg(); chk("load_stall_done", hz.stall, 1); tick();
        hz.load_done = 0;
        at_neg(); chk("pend7_clear", hz.pending[7], 0); chk("load2_accept", hz.issue_accept, 1); tick();
        idle(); hz.load_done = 1; tick(); hz.load_done = 0; repeat (4) tick();

        // reset with pipe entries in flight
        issue(1, 1, 10, 0, 0); tick();
        issue(1, 1, 11, 0, 0); tick();
        idle(); reset = 1; tick(); reset = 0;
        at_neg(); chk("rst_pipe_pending", hz.pending, 32'h0); chk("rst_pipe_wb_1", hz.wb_valid, 0); tick();
        at_neg(); chk("rst_pipe_wb_2", hz.wb_valid, 0); tick();

        // reset with the iterative unit busy, then late completion pulses
        issue(2, 1, 12, 0, 0); tick();
        idle(); reset = 1; tick(); reset = 0;
        at_neg(); chk("rst_iter_busy", hz.iter_busy, 0); chk("rst_iter_pending", hz.pending, 32'h0); tick();
        hz.iter_ready = 1; hz.load_done = 1; tick();
        idle();
        at_neg(); chk("late_ready_no_wb", hz.wb_valid, 0); tick();
        repeat (3) tick();

        // flush suppresses a clean pipelined issue
        issue(1, 1, 20, 0, 0); hz.flush = 1;
        at_neg(); chk("flush_accept", hz.issue_accept, 0); chk("flush_stall", hz.stall, 0); tick();
        idle();
        at_neg(); chk("flush_pend", hz.pending[20], 0);
        repeat (2) tick();
        at_neg(); chk("flush_no_wb", hz.wb_valid, 0); tick();

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            hz.issue_valid  = ($urandom_range(0, 9) < 7);
            hz.issue_class  = 2'($urandom_range(0, 3));
            hz.issue_fwren  = ($urandom_range(0, 3) != 0);
            hz.issue_waddr  = 5'($urandom_range(0, 7));
            hz.issue_rden1  = 1'($urandom_range(0, 1));
            hz.issue_rden2  = 1'($urandom_range(0, 1));
            hz.issue_rden3  = ($urandom_range(0, 3) == 0);
            hz.issue_raddr1 = 5'($urandom_range(0, 7));
            hz.issue_raddr2 = 5'($urandom_range(0, 7));
            hz.issue_raddr3 = 5'($urandom_range(0, 7));
            hz.flush        = ($urandom_range(0, 9) == 0);
            hz.iter_ready   = ($urandom_range(0, 5) == 0);
            hz.load_done    = ($urandom_range(0, 4) == 0);
            reset           = ($urandom_range(0, 399) == 0);
            tick();
        end

        idle();
        reset = 0;
        repeat (20) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
